// File: rtl/onebit_sequencer.sv
// onebit_sequencer: instruction store, reg/pc state and run control
// for the one-bit CPU; the ALU itself sits outside this block.
module onebit_sequencer #(
  parameter int CYC_W      = 8,
  parameter int MAX_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             load_addr,
  input  logic [1:0]       load_code,
  input  logic             start,
  input  logic             halt_req,
  output logic [1:0]       alu_code,
  output logic             alu_reg_in,
  output logic             alu_pc_in,
  input  logic             alu_reg_out,
  input  logic             alu_pc_out,
  output logic             reg_q,
  output logic             pc_q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [CYC_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_HALT  = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYCLES);
  localparam logic [CYC_W-1:0] ONE_C = CYC_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       imem0_q, imem0_d;
  logic [1:0]       imem1_q, imem1_d;
  logic             reg_d;
  logic             pc_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [1:0]       status_q, status_d;
  logic             idle_or_done;
  logic             fixed_pt;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign fixed_pt     = (alu_reg_out == reg_q) && (alu_pc_out == pc_q);

  // Next-state: program writes, run launch, commit and termination
  always_comb begin
    state_d  = state_q;
    imem0_d  = imem0_q;
    imem1_d  = imem1_q;
    reg_d    = reg_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (load_valid) begin
          if (load_addr) imem1_d = load_code;
          else           imem0_d = load_code;
        end
        if (start) begin
          state_d  = S_RUN;
          reg_d    = 1'b0;
          pc_d     = 1'b0;
          cnt_d    = '0;
          status_d = ST_NONE;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else begin
          reg_d = alu_reg_out;
          pc_d  = alu_pc_out;
          cnt_d = cnt_q + ONE_C;
          if (fixed_pt) begin
            state_d  = S_DONE;
            status_d = ST_HALT;
          end else if (cnt_d == MAX_C) begin
            state_d  = S_DONE;
            status_d = ST_TMO;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears the program store as well
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      imem0_q  <= 2'b00;
      imem1_q  <= 2'b00;
      reg_q    <= 1'b0;
      pc_q     <= 1'b0;
      cnt_q    <= '0;
      status_q <= ST_NONE;
    end else begin
      state_q  <= state_d;
      imem0_q  <= imem0_d;
      imem1_q  <= imem1_d;
      reg_q    <= reg_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  assign load_ready = idle_or_done;
  assign alu_code   = pc_q ? imem1_q : imem0_q;
  assign alu_reg_in = reg_q;
  assign alu_pc_in  = pc_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign status     = status_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_onebit_sequencer.sv
// tb_onebit_sequencer: vector table, directed corner sequences and
// random programs against a behavioural run model.
module tb_onebit_sequencer;

  localparam int CYC_W = 8;
  localparam int MAXC  = 255;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic             load_addr;
  logic [1:0]       load_code;
  logic             start;
  logic             halt_req;
  logic [1:0]       alu_code;
  logic             alu_reg_in;
  logic             alu_pc_in;
  logic             alu_reg_out;
  logic             alu_pc_out;
  logic             reg_q;
  logic             pc_q;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic [CYC_W-1:0] cycle_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  onebit_sequencer #(.CYC_W(CYC_W), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_code(load_code),
    .start(start), .halt_req(halt_req),
    .alu_code(alu_code), .alu_reg_in(alu_reg_in),
    .alu_pc_in(alu_pc_in), .alu_reg_out(alu_reg_out),
    .alu_pc_out(alu_pc_out), .reg_q(reg_q), .pc_q(pc_q),
    .busy(busy), .done(done), .status(status),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // External one-bit ALU
  always_comb begin
    alu_reg_out = alu_code[1] ? (alu_reg_in ^ alu_code[0])
                              : alu_reg_in;
    alu_pc_out  = alu_code[1] ? alu_code[0] : ~alu_pc_in;
  end

  typedef struct {
    logic [1:0] c0;
    logic [1:0] c1;
    int         h;
    logic       er;
    logic       ep;
    int         ecnt;
    logic [1:0] est;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic a, input logic [1:0] c);
    load_valid = 1'b1;
    load_addr  = a;
    load_code  = c;
    step();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // h = RUN cycle (1-based) in which halt_req is raised, 0 = never
  task automatic run_to_done(input int h);
    int cyc;
    cyc = 0;
    while (busy === 1'b1 && cyc < 400) begin
      cyc++;
      halt_req = (cyc == h);
      step();
    end
    halt_req = 1'b0;
    chk("run_ends_done", done, 1);
  endtask

  // Whole-run outcome computed from the instruction semantics
  task automatic model(input logic [1:0] c0, input logic [1:0] c1,
                       input int h, output logic r, output logic p,
                       output int n, output logic [1:0] st);
    logic [1:0] code;
    logic nr, np;
    r = 0; p = 0; n = 0; st = 0;
    for (int k = 1; k <= MAXC && st == 0; k++) begin
      if (k == h) st = 2'd3;
      else begin
        code = p ? c1 : c0;
        nr = code[1] ? (r ^ code[0]) : r;
        np = code[1] ? code[0] : ~p;
        n++;
        if (nr == r && np == p) st = 2'd1;
        r = nr;
        p = np;
        if (st == 0 && n == MAXC) st = 2'd2;
      end
    end
  endtask

  task automatic run_prog(input logic [1:0] c0, input logic [1:0] c1,
                          input int h);
    load(1'b0, c0);
    load(1'b1, c1);
    pulse_start();
    chk("busy_after_start", busy, 1);
    run_to_done(h);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic mr, mp;
    int mn;
    logic [1:0] ms, rc0, rc1;
    int rh;

    tbl[0] = '{2'b10, 2'b11, 0, 1'b0, 1'b0,    1, 2'b01};
    tbl[1] = '{2'b11, 2'b10, 0, 1'b0, 1'b1,  255, 2'b10};
    tbl[2] = '{2'b11, 2'b10, 4, 1'b0, 1'b1,    3, 2'b11};
    tbl[3] = '{2'b00, 2'b00, 0, 1'b0, 1'b1,  255, 2'b10};
    tbl[4] = '{2'b11, 2'b11, 0, 1'b1, 1'b1,  255, 2'b10};
    tbl[5] = '{2'b00, 2'b11, 0, 1'b0, 1'b1,  255, 2'b10};
    tbl[6] = '{2'b10, 2'b00, 1, 1'b0, 1'b0,    0, 2'b11};
    tbl[7] = '{2'b01, 2'b10, 0, 1'b0, 1'b1,  255, 2'b10};
    tbl[8] = '{2'b11, 2'b00, 0, 1'b0, 1'b1,  255, 2'b10};

    rst = 1'b1; load_valid = 0; load_addr = 0; load_code = 0;
    start = 0; halt_req = 0;
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_reg", reg_q, 0);
    chk("rst_pc", pc_q, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_code", alu_code, 0);

    // reset in the middle of a run
    load(1'b0, 2'b11);
    load(1'b1, 2'b10);
    pulse_start();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_reg", reg_q, 0);
    chk("mid_rst_pc", pc_q, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", load_ready, 1);
    chk("mid_rst_cnt", cycle_cnt, 0);
    chk("mid_rst_code", alu_code, 0);
    step();
    rst = 1'b0;
    step();
    pulse_start();
    chk("clr_imem0", alu_code, 0);
    step();
    chk("clr_pc1", pc_q, 1);
    chk("clr_imem1", alu_code, 0);
    run_to_done(1);

    // vector table
    for (int i = 0; i < 9; i++) begin
      run_prog(tbl[i].c0, tbl[i].c1, tbl[i].h);
      chk($sformatf("tbl%0d_reg", i), reg_q, tbl[i].er);
      chk($sformatf("tbl%0d_pc", i), pc_q, tbl[i].ep);
      chk($sformatf("tbl%0d_cnt", i), cycle_cnt, tbl[i].ecnt);
      chk($sformatf("tbl%0d_status", i), status, tbl[i].est);
      chk($sformatf("tbl%0d_ready", i), load_ready, 1);
    end

    // loads and start ignored while running
    load(1'b0, 2'b11);
    load(1'b1, 2'b10);
    pulse_start();
    for (int c = 1; c <= 5; c++) begin
      load_valid = 1'b1;
      load_addr  = 1'b0;
      load_code  = 2'b00;
      start      = 1'b1;
      halt_req   = (c == 5);
      chk($sformatf("run_ready_c%0d", c), load_ready, 0);
      if (c == 5) chk("run_imem0_kept", alu_code, 2'b11);
      step();
    end
    load_valid = 0; start = 0; halt_req = 0;
    chk("ign_done", done, 1);
    chk("ign_status", status, 2'b11);
    chk("ign_cnt", cycle_cnt, 4);
    chk("ign_reg", reg_q, 0);
    chk("ign_pc", pc_q, 0);
    chk("ign_code", alu_code, 2'b11);
    load(1'b0, 2'b00);
    chk("done_load_code", alu_code, 2'b00);

    // load and start in the same DONE cycle
    load_valid = 1'b1;
    load_addr  = 1'b0;
    load_code  = 2'b10;
    start      = 1'b1;
    step();
    load_valid = 0; start = 0;
    chk("ls_busy", busy, 1);
    chk("ls_reg", reg_q, 0);
    chk("ls_pc", pc_q, 0);
    chk("ls_code", alu_code, 2'b10);
    run_to_done(0);
    chk("ls_status", status, 2'b01);
    chk("ls_cnt", cycle_cnt, 1);

    // random programs against the model
    for (int t = 0; t < 24; t++) begin
      rc0 = 2'($urandom_range(0, 3));
      rc1 = 2'($urandom_range(0, 3));
      rh  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : 0;
      model(rc0, rc1, rh, mr, mp, mn, ms);
      run_prog(rc0, rc1, rh);
      chk($sformatf("rnd%0d_reg", t), reg_q, mr);
      chk($sformatf("rnd%0d_pc", t), pc_q, mp);
      chk($sformatf("rnd%0d_cnt", t), cycle_cnt, mn);
      chk($sformatf("rnd%0d_status", t), status, ms);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
